// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state codes, opcode and
// ALU function constants, IR field positions and the strobe bundle type.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_HALT  = 4'd8,
    ST_FAULT = 4'd9
  } state_e;

  // IR field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // Opcodes
  localparam logic [4:0] OPC_ADD  = 5'b00000;
  localparam logic [4:0] OPC_SUB  = 5'b00001;
  localparam logic [4:0] OPC_AND  = 5'b00010;
  localparam logic [4:0] OPC_OR   = 5'b00011;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;

  // Single-bit datapath strobes, in port order
  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic md_read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic ry_in;
    logic rz_in;
    logic zlow_out;
    logic hi_in;
    logic lo_in;
    logic lo_out;
    logic hi_out;
  } strobe_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath signal bundle. The master side is the sequencer
// (drives strobes), the slave side is the datapath / surrounding system.
interface control_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
);
  logic              run;
  logic [DATA_W-1:0] ir;
  logic              mem_ready;

  logic [NREG-1:0]   reg_sel;
  logic [NREG-1:0]   reg_in;

  logic pc_out, pc_in, inc_pc, mar_in, md_read, mdr_in, mdr_out, ir_in;
  logic ry_in, rz_in, zlow_out, hi_in, lo_in, lo_out, hi_out;

  logic [3:0]        alu_op;
  logic [3:0]        state;
  logic              busy;
  logic              fault;

  modport master (
    input  run, ir, mem_ready,
    output reg_sel, reg_in,
    output pc_out, pc_in, inc_pc, mar_in, md_read, mdr_in, mdr_out, ir_in,
    output ry_in, rz_in, zlow_out, hi_in, lo_in, lo_out, hi_out,
    output alu_op, state, busy, fault
  );

  modport slave (
    output run, ir, mem_ready,
    input  reg_sel, reg_in,
    input  pc_out, pc_in, inc_pc, mar_in, md_read, mdr_in, mdr_out, ir_in,
    input  ry_in, rz_in, zlow_out, hi_in, lo_in, lo_out, hi_out,
    input  alu_op, state, busy, fault
  );
endinterface

// File: rtl/control_sequencer_opcode_decoder.sv
// Combinational opcode classifier for the control sequencer.
// Build option: MULDIV_EN -- when defined MUL/DIV decode as multi-cycle
// HI/LO operations, otherwise they are treated as illegal opcodes.
module opcode_decoder
  import control_sequencer_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [3:0] alu_op,
  output logic       is_alu,
  output logic       is_muldiv,
  output logic       is_halt,
  output logic       illegal
);

  // Map opcode to ALU function and instruction class
  always_comb begin
    alu_op    = 4'h0;
    is_alu    = 1'b0;
    is_muldiv = 1'b0;
    is_halt   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_ADD:  begin alu_op = ALU_ADD; is_alu = 1'b1; end
      OPC_SUB:  begin alu_op = ALU_SUB; is_alu = 1'b1; end
      OPC_AND:  begin alu_op = ALU_AND; is_alu = 1'b1; end
      OPC_OR:   begin alu_op = ALU_OR;  is_alu = 1'b1; end
`ifdef MULDIV_EN
      OPC_MUL:  begin alu_op = ALU_MUL; is_muldiv = 1'b1; end
      OPC_DIV:  begin alu_op = ALU_DIV; is_muldiv = 1'b1; end
`else
      OPC_MUL,
      OPC_DIV:  illegal = 1'b1;
`endif
      OPC_HALT: is_halt = 1'b1;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2), decode (T3) and execute
// (T4-T6) for a single-bus register-file datapath. All strobes are
// registered and decoded from the next state, so they are glitch-free and
// valid for the whole state.
// Build option: MULDIV_EN -- enables MUL/DIV (HI/LO write-back through T6).
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREG    = 16,
  parameter int MEM_TMO = 15
) (
  input logic                 clk,
  input logic                 reset,
  control_sequencer_if.master bus
);

  localparam int CNT_W = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d, wait_inc;
  strobe_t           strb_q, strb_d;
  logic [NREG-1:0]   reg_sel_q, reg_sel_d;
  logic [NREG-1:0]   reg_in_q, reg_in_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;

  logic [DATA_W-1:0] ir_w;
  logic [4:0]        opcode;
  logic [3:0]        ra, rb, rc;
  int                ra_wrap;
  logic              field_bad;
  logic [3:0]        dec_alu_op;
  logic              is_alu, is_muldiv, is_halt, illegal;

  // Low IR bits are immediate/unused fields for this sequencer
  logic              unused_ir;

  assign ir_w      = bus.ir;
  assign unused_ir = ^ir_w;
  assign opcode    = ir_w[OPC_MSB:OPC_LSB];
  assign ra        = ir_w[RA_MSB:RA_LSB];
  assign rb        = ir_w[RB_MSB:RB_LSB];
  assign rc        = ir_w[RC_MSB:RC_LSB];
  assign ra_wrap   = (int'(ra) + 1) % NREG;

  // A register field outside the implemented file can only occur when NREG < 16
  generate
    if (NREG < 16) begin : g_field_chk
      assign field_bad = (int'(ra) >= NREG) || (int'(rb) >= NREG) ||
                         (int'(rc) >= NREG);
    end else begin : g_no_field_chk
      assign field_bad = 1'b0;
    end
  endgenerate

  opcode_decoder u_dec (
    .opcode    (opcode),
    .alu_op    (dec_alu_op),
    .is_alu    (is_alu),
    .is_muldiv (is_muldiv),
    .is_halt   (is_halt),
    .illegal   (illegal)
  );

  // One-hot register select; an out-of-range index yields all zeros
  function automatic logic [NREG-1:0] onehot(input int idx);
    return NREG'(1) << idx;
  endfunction

  // Next-state logic plus strobe decode of the state being entered
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    wait_inc   = wait_cnt_q + CNT_W'(1);
    strb_d     = '0;
    reg_sel_d  = '0;
    reg_in_d   = '0;
    alu_op_d   = 4'h0;

    case (state_q)
      ST_IDLE:  if (bus.run) state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1: begin
        if (bus.mem_ready) begin
          state_d = ST_T2;
        end else if (wait_inc == CNT_W'(MEM_TMO)) begin
          state_d = ST_FAULT;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      ST_T2:    state_d = ST_T3;
      ST_T3: begin
        if (is_halt)                   state_d = ST_HALT;
        else if (illegal || field_bad) state_d = ST_FAULT;
        else                           state_d = ST_T4;
      end
      ST_T4:    state_d = ST_T5;
`ifdef MULDIV_EN
      ST_T5:    state_d = is_muldiv ? ST_T6 : ST_T0;
      ST_T6:    state_d = ST_T0;
`else
      ST_T5:    state_d = ST_T0;
`endif
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    case (state_d)
      ST_T0: begin
        strb_d.pc_out = 1'b1;
        strb_d.mar_in = 1'b1;
        strb_d.inc_pc = 1'b1;
        strb_d.rz_in  = 1'b1;
      end
      ST_T1: begin
        strb_d.zlow_out = 1'b1;
        strb_d.md_read  = 1'b1;
        strb_d.mdr_in   = 1'b1;
        // PC takes the incremented value once, on entry to the memory wait
        strb_d.pc_in    = (state_q != ST_T1);
      end
      ST_T2: begin
        strb_d.mdr_out = 1'b1;
        strb_d.ir_in   = 1'b1;
      end
      ST_T3: begin
        reg_sel_d    = onehot(int'(rb));
        strb_d.ry_in = 1'b1;
      end
      ST_T4: begin
        reg_sel_d = onehot(int'(rc));
        alu_op_d  = dec_alu_op;
        if (is_alu) strb_d.rz_in = 1'b1;
`ifdef MULDIV_EN
        if (is_muldiv) begin
          strb_d.hi_in = 1'b1;
          strb_d.lo_in = 1'b1;
        end
`endif
      end
      ST_T5: begin
        reg_in_d = onehot(int'(ra));
        if (is_alu) strb_d.zlow_out = 1'b1;
`ifdef MULDIV_EN
        if (is_muldiv) strb_d.lo_out = 1'b1;
`endif
      end
`ifdef MULDIV_EN
      ST_T6: begin
        reg_in_d      = onehot(ra_wrap);
        strb_d.hi_out = 1'b1;
      end
`endif
      default: ;
    endcase

    busy_d  = !(state_d inside {ST_IDLE, ST_HALT, ST_FAULT});
    fault_d = (state_d == ST_FAULT);
  end

  // State, wait counter and registered strobes; reset clears everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      strb_q     <= '0;
      reg_sel_q  <= '0;
      reg_in_q   <= '0;
      alu_op_q   <= 4'h0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      strb_q     <= strb_d;
      reg_sel_q  <= reg_sel_d;
      reg_in_q   <= reg_in_d;
      alu_op_q   <= alu_op_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.reg_sel  = reg_sel_q;
  assign bus.reg_in   = reg_in_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.busy     = busy_q;
  assign bus.fault    = fault_q;
  assign bus.pc_out   = strb_q.pc_out;
  assign bus.pc_in    = strb_q.pc_in;
  assign bus.inc_pc   = strb_q.inc_pc;
  assign bus.mar_in   = strb_q.mar_in;
  assign bus.md_read  = strb_q.md_read;
  assign bus.mdr_in   = strb_q.mdr_in;
  assign bus.mdr_out  = strb_q.mdr_out;
  assign bus.ir_in    = strb_q.ir_in;
  assign bus.ry_in    = strb_q.ry_in;
  assign bus.rz_in    = strb_q.rz_in;
  assign bus.zlow_out = strb_q.zlow_out;

`ifdef MULDIV_EN
  assign bus.hi_in    = strb_q.hi_in;
  assign bus.lo_in    = strb_q.lo_in;
  assign bus.lo_out   = strb_q.lo_out;
  assign bus.hi_out   = strb_q.hi_out;
`else
  // HI/LO path absent in this build
  logic unused_muldiv;
  assign unused_muldiv = ^{is_muldiv, strb_q.hi_in, strb_q.lo_in,
                           strb_q.lo_out, strb_q.hi_out};
  assign bus.hi_in    = 1'b0;
  assign bus.lo_in    = 1'b0;
  assign bus.lo_out   = 1'b0;
  assign bus.hi_out   = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed scenarios followed by random
// instruction streams, checked cycle by cycle against an instruction-level
// expectation list built from the sequencing rules.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  localparam int DATA_W  = 32;
  localparam int NREG    = 16;
  localparam int MEM_TMO = 15;
  localparam int W       = 4 + 15 + 4 + 2 * NREG + 2;

  localparam int K_ALU = 0, K_MULDIV = 1, K_HALT = 2, K_ILL = 3;

  // Strobe masks, port order pc_out (MSB) .. hi_out (LSB)
  localparam logic [14:0] S_PC_OUT   = 15'h4000;
  localparam logic [14:0] S_PC_IN    = 15'h2000;
  localparam logic [14:0] S_INC_PC   = 15'h1000;
  localparam logic [14:0] S_MAR_IN   = 15'h0800;
  localparam logic [14:0] S_MD_READ  = 15'h0400;
  localparam logic [14:0] S_MDR_IN   = 15'h0200;
  localparam logic [14:0] S_MDR_OUT  = 15'h0100;
  localparam logic [14:0] S_IR_IN    = 15'h0080;
  localparam logic [14:0] S_RY_IN    = 15'h0040;
  localparam logic [14:0] S_RZ_IN    = 15'h0020;
  localparam logic [14:0] S_ZLOW_OUT = 15'h0010;
  localparam logic [14:0] S_HI_IN    = 15'h0008;
  localparam logic [14:0] S_LO_IN    = 15'h0004;
  localparam logic [14:0] S_LO_OUT   = 15'h0002;
  localparam logic [14:0] S_HI_OUT   = 15'h0001;

  typedef struct {
    logic [3:0]      st;
    logic [14:0]     strb;
    logic [3:0]      alu;
    logic [NREG-1:0] sel;
    logic [NREG-1:0] rin;
    logic            busy;
    logic            fault;
    logic            mr;
    logic [31:0]     ir;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if #(.DATA_W(DATA_W), .NREG(NREG)) bus();

  control_sequencer #(.DATA_W(DATA_W), .NREG(NREG), .MEM_TMO(MEM_TMO)) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  int    checks = 0;
  int    errors = 0;
  string phase;
  exp_t  q[$];

  function automatic logic [W-1:0] observed();
    return {bus.state, bus.pc_out, bus.pc_in, bus.inc_pc, bus.mar_in,
            bus.md_read, bus.mdr_in, bus.mdr_out, bus.ir_in, bus.ry_in,
            bus.rz_in, bus.zlow_out, bus.hi_in, bus.lo_in, bus.lo_out,
            bus.hi_out, bus.alu_op, bus.reg_sel, bus.reg_in, bus.busy,
            bus.fault};
  endfunction

  function automatic logic [W-1:0] pack(input exp_t e);
    return {e.st, e.strb, e.alu, e.sel, e.rin, e.busy, e.fault};
  endfunction

  function automatic logic [W-1:0] idle_vec();
    return {4'(ST_IDLE), {(W-4){1'b0}}};
  endfunction

  function automatic logic [NREG-1:0] bit_of(input int i);
    logic [NREG-1:0] v;
    v = '0;
    if (i >= 0 && i < NREG) v[i] = 1'b1;
    return v;
  endfunction

  // Instruction class and ALU code straight from the opcode table
  function automatic int classify(input logic [4:0] opc, output logic [3:0] alu);
    alu = 4'h0;
    case (opc)
      5'b00000: begin alu = 4'b0000; return K_ALU; end
      5'b00001: begin alu = 4'b0001; return K_ALU; end
      5'b00010: begin alu = 4'b0011; return K_ALU; end
      5'b00011: begin alu = 4'b0100; return K_ALU; end
`ifdef MULDIV_EN
      5'b01111: begin alu = 4'b0010; return K_MULDIV; end
      5'b10000: begin alu = 4'b0101; return K_MULDIV; end
`endif
      5'b11011: return K_HALT;
      default:  return K_ILL;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic void push(input state_e st, input logic [14:0] strb,
                               input logic [3:0] alu, input logic [NREG-1:0] sel,
                               input logic [NREG-1:0] rin, input logic mr,
                               input logic [31:0] irv);
    exp_t e;
    e.st    = 4'(st);
    e.strb  = strb;
    e.alu   = alu;
    e.sel   = sel;
    e.rin   = rin;
    e.busy  = !(st inside {ST_IDLE, ST_HALT, ST_FAULT});
    e.fault = (st == ST_FAULT);
    e.mr    = mr;
    e.ir    = irv;
    q.push_back(e);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Terminal states are checked on entry and for two further cycles
  function automatic void push_term(input state_e st, input logic [31:0] irv);
    for (int i = 0; i < 3; i++) push(st, '0, 4'h0, '0, '0, rbit(), irv);
  endfunction

  // Expected per-cycle trace of one instruction starting at T0; w is the
  // number of mem_ready=0 cycles in the fetch wait. Returns 1 when the
  // instruction ends in HALT or FAULT.
  function automatic int build(input logic [31:0] irv, input int w);
    int         ra, rb, rc, kind;
    logic [3:0] alu;
    ra   = int'(irv[26:23]);
    rb   = int'(irv[22:19]);
    rc   = int'(irv[18:15]);
    kind = classify(irv[31:27], alu);
    push(ST_T0, S_PC_OUT | S_MAR_IN | S_INC_PC | S_RZ_IN, 4'h0, '0, '0, rbit(), irv);
    if (w >= MEM_TMO) begin
      for (int i = 0; i < MEM_TMO; i++)
        push(ST_T1, (i == 0 ? S_PC_IN : 15'h0) | S_ZLOW_OUT | S_MD_READ | S_MDR_IN,
             4'h0, '0, '0, 1'b0, irv);
      push_term(ST_FAULT, irv);
      return 1;
    end
    for (int i = 0; i <= w; i++)
      push(ST_T1, (i == 0 ? S_PC_IN : 15'h0) | S_ZLOW_OUT | S_MD_READ | S_MDR_IN,
           4'h0, '0, '0, (i == w), irv);
    push(ST_T2, S_MDR_OUT | S_IR_IN, 4'h0, '0, '0, rbit(), irv);
    push(ST_T3, S_RY_IN, 4'h0, bit_of(rb), '0, rbit(), irv);
    if (kind == K_HALT) begin
      push_term(ST_HALT, irv);
      return 1;
    end
    if (kind == K_ILL || ra >= NREG || rb >= NREG || rc >= NREG) begin
      push_term(ST_FAULT, irv);
      return 1;
    end
    if (kind == K_ALU) begin
      push(ST_T4, S_RZ_IN, alu, bit_of(rc), '0, rbit(), irv);
      push(ST_T5, S_ZLOW_OUT, 4'h0, '0, bit_of(ra), rbit(), irv);
    end else begin
      push(ST_T4, S_HI_IN | S_LO_IN, alu, bit_of(rc), '0, rbit(), irv);
      push(ST_T5, S_LO_OUT, 4'h0, '0, bit_of(ra), rbit(), irv);
      push(ST_T6, S_HI_OUT, 4'h0, '0, bit_of((ra + 1) % NREG), rbit(), irv);
    end
    return 0;
  endfunction

  // Check up to n queued cycles; inputs for the next edge are applied after each check
  task automatic play(input int n);
    exp_t e;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      e = q.pop_front();
      chk($sformatf("%s cyc%0d st%0d", phase, k, e.st), observed(), pack(e));
      bus.mem_ready = e.mr;
      bus.ir        = e.ir;
      bus.run       = rbit();
      @(negedge clk);
    end
  endtask

  // Reset, confirm IDLE holds with run=0, then launch; returns in the T0 cycle
  task automatic start(input string name);
    phase = name;
    q.delete();
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ir        = $urandom;
    reset_n       = 1'b0;
    @(negedge clk);
    chk({name, "_in_reset"}, observed(), idle_vec());
    reset_n = 1'b1;
    @(negedge clk);
    chk({name, "_idle"}, observed(), idle_vec());
    bus.run = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {opc, ra, rb, rc, 15'($urandom)};
  endfunction

  initial begin
    int          term;
    int          cat;
    logic [4:0]  opc;
    logic [4:0]  ops [6];
    exp_t        e;

    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01111, 5'b10000};

    // ADD r1,r2,r2 with no wait, back-to-back SUB with 3 wait cycles, then HALT
    start("add_sub_halt");
    term = build(32'h0091_0000, 0);
    play(q.size());
    term = build(mk_ir(5'b00001, 4'd5, 4'd7, 4'd9), 3);
    play(q.size());
    term = build(mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 1);
    play(q.size());

    // Memory never ready: fault after MEM_TMO wait cycles
    start("mem_timeout");
    term = build(mk_ir(5'b00000, 4'd1, 4'd1, 4'd1), MEM_TMO);
    play(q.size());

    // MUL r3,r2,r1 (HI/LO write-back, or fault without the option)
    start("mul");
    term = build({5'b01111, 4'd3, 4'd2, 4'd1, 15'd0}, 0);
    play(q.size());

    // DIV into r15 so the HI destination wraps to r0
    start("div_wrap");
    term = build(mk_ir(5'b10000, 4'd15, 4'd4, 4'd6), 2);
    play(q.size());

    // Undefined opcode
    start("opc_11111");
    term = build(mk_ir(5'b11111, 4'd2, 4'd3, 4'd4), 0);
    play(q.size());

    // Reset asserted during T4, then relaunch
    start("reset_t4");
    term = build(mk_ir(5'b00010, 4'd6, 4'd8, 4'd10), 0);
    play(4);
    e = q.pop_front();
    chk("reset_t4 pre", observed(), pack(e));
    reset_n = 1'b0;
    #1;
    chk("reset_t4 async", observed(), idle_vec());
    q.delete();
    reset_n = 1'b1;
    bus.run = 1'b1;
    @(negedge clk);
    phase = "reset_t4_relaunch";
    term = build(mk_ir(5'b00011, 4'd11, 4'd12, 4'd13), 0);
    play(q.size());

    // Reset during the memory wait; the wait count must restart from zero
    start("reset_wait");
    term = build(mk_ir(5'b00000, 4'd1, 4'd2, 4'd3), 5);
    play(3);
    reset_n = 1'b0;
    #1;
    chk("reset_wait async", observed(), idle_vec());
    q.delete();
    reset_n = 1'b1;
    bus.run = 1'b1;
    @(negedge clk);
    phase = "reset_wait_relaunch";
    term = build(mk_ir(5'b00001, 4'd4, 4'd5, 4'd6), MEM_TMO - 1);
    play(q.size());

    // Random instruction streams
    for (int p = 0; p < 30; p++) begin
      start($sformatf("rand%0d", p));
      for (int n = 0; n < 4; n++) begin
        cat = $urandom_range(0, 19);
        if (cat == 0) begin
          opc = 5'b11011;
        end else if (cat == 1) begin
          do opc = 5'($urandom_range(0, 31));
          while (opc inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                             5'b01111, 5'b10000, 5'b11011});
        end else begin
          opc = ops[$urandom_range(0, 5)];
        end
        term = build(mk_ir(opc, 4'($urandom), 4'($urandom), 4'($urandom)),
                     (cat == 2) ? MEM_TMO : $urandom_range(0, 4));
        play(q.size());
        if (term != 0) break;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
